serial_receiver: RTL

Receiving end of the three-wire serial link (`transmission`, `clock`, `data`) driven by the board's transmitter. Oversamples the three link lines in the local `clk` domain and shifts in bits on each rising edge of the serial clock. Presents each completed word with a one-cycle valid strobe, and flags frames that end mid-word. Sits between the board input pins and the consumer logic (LED display / command decode).

---
 rtl/serial_pkg.sv | 16 +
 rtl/sync_edge.sv | 46 ++++
 rtl/serial_receiver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the three-wire serial link (transmission/clock/data).
// Contents:
//   rx_state_t       receiver FSM state (IDLE, RECV)
//   SERIAL_WIDTH     bits per word, also used by the transmitter
//   SYNC_STAGES_DEF  default synchronizer depth per link input
package serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam int SERIAL_WIDTH    = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge.sv
// Synchronizer chain plus edge detector for one asynchronous input.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   async_i  in   asynchronous input line
//   level_o  out  synchronized level (last stage of the chain)
//   rise_o   out  one-cycle strobe, registered, level went 0 -> 1
//   fall_o   out  one-cycle strobe, registered, level went 1 -> 0
// STAGES must be at least 2.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Edge strobes are registered so that a rise is acted on exactly
  // STAGES+1 clk edges after the raw line is first sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
      rise_q  <= chain_q[STAGES-1] & ~prev_q;
      fall_q  <= ~chain_q[STAGES-1] & prev_q;
    end
  end

  assign level_o = chain_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/serial_receiver.sv
// Receiving end of the three-wire serial link. The link lines are
// oversampled in the clk domain; a bit is shifted in on every rising edge
// of the serial clock while a frame (transmission high) is open.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   transmission  in   frame enable from the link (asynchronous)
//   clock         in   serial bit clock from the link (asynchronous)
//   data          in   serial data from the link
//   word          out  last completed word, held until the next one
//   valid         out  one-cycle strobe, word is new this cycle
//   frame_err     out  one-cycle strobe, frame ended with a partial word
//   busy          out  high while a frame is being received
//   state_o       out  current FSM state, for observation
// Handshake: valid/frame_err are plain strobes with no ready; the consumer
// must capture word in the cycle valid is high. Both are never high together.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH       = SERIAL_WIDTH,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             transmission,
  input  logic             clock,
  input  logic             data,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             frame_err,
  output logic             busy,
  output rx_state_t        state_o
);

  localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [7:0]      WARM_LAST = 8'(SYNC_STAGES + 1);

  // Synchronized link lines and edge strobes.
  logic tx_s, tx_rise, tx_fall;
  logic sck_s, sck_rise, sck_fall;
  logic dat_s, dat_rise, dat_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_tx_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (transmission),
    .level_o (tx_s),
    .rise_o  (tx_rise),
    .fall_o  (tx_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (clock),
    .level_o (sck_s),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_dat_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (data),
    .level_o (dat_s),
    .rise_o  (dat_rise),
    .fall_o  (dat_fall)
  );

  // Only the data level and the serial-clock rise matter here.
  logic edge_unused;
  assign edge_unused = ^{sck_s, sck_fall, dat_rise, dat_fall};

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] shifted;

  // Frame-start arming. Reset clears the synchronizers to 0, so if reset
  // lands mid-frame the refilled chain would look like a fresh tx rise.
  // A frame start is only accepted once the synchronized transmission line
  // has been seen low after the chain has refilled.
  logic [7:0] warm_q;
  logic       armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      if (warm_q != WARM_LAST) begin
        warm_q <= warm_q + 8'd1;
      end
      if ((warm_q == WARM_LAST) && !tx_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {sh_q[WIDTH-2:0], dat_s};
    end else begin
      shifted = {dat_s, sh_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    word_d  = word_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_rise && armed_q) begin
          state_d = RECV;
          sh_d    = '0;
        end
      end
      RECV: begin
        // The bit is taken before the frame end is evaluated, so a bit
        // that completes a word in the same cycle as tx_fall is a clean end.
        if (sck_rise) begin
          sh_d = shifted;
          if (cnt_q == CNT_LAST) begin
            word_d  = shifted;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (tx_fall) begin
          if (cnt_d != '0) begin
            ferr_d = 1'b1;
          end
          sh_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign word      = word_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q == RECV);
  assign state_o   = state_q;

endmodule
